// File: rtl/network_mac_operand_gen.sv
// Operand generator for the 11x5 multiplier: walks op_a (outer) x op_b (inner), one pair per cycle.
// First pair appears 1 cycle after ap_start is accepted; a pair is held stable while out_ready is low.
module network_mac_operand_gen #(
  parameter int A_WIDTH    = 11,
  parameter int B_WIDTH    = 5,
  parameter int ACNT_WIDTH = 12,
  parameter int BCNT_WIDTH = 6
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  ap_start,
  output logic                  ap_done,
  output logic                  ap_idle,
  output logic                  ap_ready,
  input  logic [A_WIDTH-1:0]    a_base_in,
  input  logic [ACNT_WIDTH-1:0] a_count_in,
  input  logic [BCNT_WIDTH-1:0] b_count_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [A_WIDTH-1:0]    op_a,
  output logic [B_WIDTH-1:0]    op_b,
  output logic                  out_last
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [ACNT_WIDTH-1:0] A_ONE = ACNT_WIDTH'(1);
  localparam logic [BCNT_WIDTH-1:0] B_ONE = BCNT_WIDTH'(1);

  state_t                  state;
  logic [A_WIDTH-1:0]      a_base;
  logic [ACNT_WIDTH-1:0]   a_cnt;
  logic [BCNT_WIDTH-1:0]   b_cnt;
  logic [ACNT_WIDTH-1:0]   a_idx;
  logic [BCNT_WIDTH-1:0]   b_idx;

  logic                    b_wrap;
  logic [ACNT_WIDTH-1:0]   a_nxt;
  logic [BCNT_WIDTH-1:0]   b_nxt;
  logic                    last_nxt;

  // Index state for the beat that follows the one currently presented.
  always_comb begin
    b_wrap   = (b_idx == b_cnt - B_ONE);
    a_nxt    = b_wrap ? a_idx + A_ONE : a_idx;
    b_nxt    = b_wrap ? '0 : b_idx + B_ONE;
    last_nxt = (a_nxt == a_cnt - A_ONE) && (b_nxt == b_cnt - B_ONE);
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state     <= IDLE;
      ap_idle   <= 1'b1;
      ap_done   <= 1'b0;
      ap_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      op_a      <= '0;
      op_b      <= '0;
      a_base    <= '0;
      a_cnt     <= '0;
      b_cnt     <= '0;
      a_idx     <= '0;
      b_idx     <= '0;
    end else begin
      case (state)
        IDLE: begin
          ap_done  <= 1'b0;
          ap_ready <= 1'b0;
          if (ap_start) begin
            a_base  <= a_base_in;
            a_cnt   <= a_count_in;
            b_cnt   <= b_count_in;
            a_idx   <= '0;
            b_idx   <= '0;
            op_a    <= a_base_in;
            op_b    <= '0;
            ap_idle <= 1'b0;
            if (a_count_in == '0 || b_count_in == '0) begin
              // Empty loop nest: report completion without emitting any pair.
              state    <= DONE;
              ap_done  <= 1'b1;
              ap_ready <= 1'b1;
              out_last <= 1'b0;
            end else begin
              state     <= RUN;
              out_valid <= 1'b1;
              out_last  <= (a_count_in == A_ONE) && (b_count_in == B_ONE);
            end
          end
        end
        RUN: begin
          if (out_valid && out_ready) begin
            if (out_last) begin
              state     <= DONE;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              ap_done   <= 1'b1;
              ap_ready  <= 1'b1;
            end else begin
              a_idx    <= a_nxt;
              b_idx    <= b_nxt;
              op_a     <= a_base + a_nxt[A_WIDTH-1:0];
              op_b     <= b_nxt[B_WIDTH-1:0];
              out_last <= last_nxt;
            end
          end
        end
        DONE: begin
          state    <= IDLE;
          ap_done  <= 1'b0;
          ap_ready <= 1'b0;
          ap_idle  <= 1'b1;
        end
        default: begin
          state   <= IDLE;
          ap_idle <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_network_mac_operand_gen.sv
// Scoreboard bench for network_mac_operand_gen: directed runs, expected beats queued, monitor compares.
module tb_network_mac_operand_gen;

  logic        ap_clk = 1'b0;
  logic        ap_rst;
  logic        ap_start;
  logic        ap_done, ap_idle, ap_ready;
  logic [10:0] a_base_in;
  logic [11:0] a_count_in;
  logic [5:0]  b_count_in;
  logic        out_valid;
  logic        out_ready;
  logic [10:0] op_a;
  logic [4:0]  op_b;
  logic        out_last;

  network_mac_operand_gen dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(ap_start),
    .ap_done(ap_done), .ap_idle(ap_idle), .ap_ready(ap_ready),
    .a_base_in(a_base_in), .a_count_in(a_count_in), .b_count_in(b_count_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .op_a(op_a), .op_b(op_b), .out_last(out_last)
  );

  initial forever #5 ap_clk = ~ap_clk;

  typedef struct packed {
    logic [10:0] a;
    logic [4:0]  b;
    logic        l;
  } beat_t;

  beat_t sb[$];
  int    n_chk = 0;
  int    n_fail = 0;
  int    cyc = 0;
  int    xfer_count = 0;
  int    last_xfer_cyc = -1;
  int    done_seen = 0;
  int    done_cyc = -1;
  int    ready_mode = 0;
  int    rcnt = 0;

  task automatic chk(input bit ok, input string nm, input int act, input int exp);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(posedge ap_clk) cyc++;

  // Downstream ready: constant 1, or the repeating 1,0,0 pattern.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge ap_clk);
      #1;
      rcnt++;
      out_ready = (ready_mode != 0) ? (rcnt % 3 == 1) : 1'b1;
    end
  end

  // Monitor: pops the scoreboard on every transfer, checks stability under backpressure.
  beat_t held;
  bit    hold = 1'b0;
  always @(negedge ap_clk) begin
    beat_t cur, exp;
    cur = '{a: op_a, b: op_b, l: out_last};
    if (ap_rst) begin
      hold = 1'b0;
    end else begin
      if (hold)
        chk(out_valid && (cur == held), "hold_stable", int'({out_valid, cur}), int'({1'b1, held}));
      if (out_valid) begin
        chk(int'(op_a) * int'(op_b) < 16384, "product_range", int'(op_a) * int'(op_b), 16383);
        if (out_ready) begin
          chk(sb.size() != 0, "unexpected_beat", int'(cur), 0);
          if (sb.size() != 0) begin
            exp = sb.pop_front();
            chk(cur == exp, "beat", int'(cur), int'(exp));
          end
          xfer_count++;
          if (out_last) last_xfer_cyc = cyc;
        end
      end
      hold = out_valid && !out_ready;
      held = cur;
      if (ap_done) done_seen++;
    end
  end

  task automatic push_run(input int base, input int ac, input int bc, input int limit);
    int n = 0;
    for (int i = 0; i < ac; i++)
      for (int j = 0; j < bc; j++) begin
        beat_t e;
        e.a = 11'(base + i);
        e.b = 5'(j);
        e.l = (i == ac - 1) && (j == bc - 1);
        if (limit < 0 || n < limit) sb.push_back(e);
        n++;
      end
  endtask

  // One-cycle start pulse, then scramble the config to show it was latched.
  task automatic start_run(input int base, input int ac, input int bc);
    @(posedge ap_clk); #1;
    a_base_in  = 11'(base);
    a_count_in = 12'(ac);
    b_count_in = 6'(bc);
    ap_start   = 1'b1;
    @(posedge ap_clk); #1;
    ap_start   = 1'b0;
    a_base_in  = 11'h3a5;
    a_count_in = 12'd7;
    b_count_in = 6'd9;
  endtask

  task automatic wait_done(input int bound, input string nm);
    bit got = 1'b0;
    for (int k = 0; k < bound && !got; k++) begin
      @(negedge ap_clk);
      if (ap_done) got = 1'b1;
    end
    chk(got, {nm, "_done_seen"}, int'(got), 1);
    if (got) begin
      done_cyc = cyc;
      chk(ap_ready == 1'b1 && ap_idle == 1'b0, {nm, "_done_flags"},
          int'({ap_ready, ap_idle}), 2);
    end
  endtask

  task automatic check_idle(input string nm);
    @(negedge ap_clk);
    chk(ap_idle && !ap_done && !out_valid, nm, int'({ap_idle, ap_done, out_valid}), 4);
  endtask

  initial begin
    int d1, target, dseen;
    ap_rst = 1'b1; ap_start = 1'b0;
    a_base_in = '0; a_count_in = '0; b_count_in = '0;
    repeat (3) @(posedge ap_clk);
    @(negedge ap_clk);
    chk({ap_idle, ap_done, ap_ready, out_valid, op_a, op_b, out_last} == {1'b1, 3'b000, 11'd0, 5'd0, 1'b0},
        "reset_state", int'({ap_idle, ap_done, ap_ready, out_valid, op_a, op_b, out_last}),
        int'({1'b1, 3'b000, 11'd0, 5'd0, 1'b0}));
    @(posedge ap_clk); #1;
    ap_rst = 1'b0;

    // Basic run, ready held high.
    push_run(5, 2, 3, -1);
    start_run(5, 2, 3);
    @(negedge ap_clk);
    chk(out_valid && op_a == 11'd5 && op_b == 5'd0, "first_beat_latency", int'({out_valid, op_a, op_b}),
        int'({1'b1, 11'd5, 5'd0}));
    wait_done(20, "basic");
    chk(done_cyc == last_xfer_cyc + 1, "basic_done_timing", done_cyc, last_xfer_cyc + 1);
    chk(sb.size() == 0, "basic_drained", sb.size(), 0);
    check_idle("basic_idle_after");

    // Same run under 1,0,0 backpressure.
    ready_mode = 1;
    push_run(5, 2, 3, -1);
    start_run(5, 2, 3);
    wait_done(60, "bp");
    chk(done_cyc == last_xfer_cyc + 1, "bp_done_timing", done_cyc, last_xfer_cyc + 1);
    chk(sb.size() == 0, "bp_drained", sb.size(), 0);
    check_idle("bp_idle_after");
    ready_mode = 0;

    // op_a wraps past 2047 with b_count=1.
    push_run(2046, 3, 1, -1);
    start_run(2046, 3, 1);
    wait_done(20, "wrap");
    chk(sb.size() == 0, "wrap_drained", sb.size(), 0);
    check_idle("wrap_idle_after");

    // Full inner range: op_b 0..31.
    push_run(100, 1, 32, -1);
    start_run(100, 1, 32);
    wait_done(50, "b32");
    chk(sb.size() == 0, "b32_drained", sb.size(), 0);
    check_idle("b32_idle_after");

    // Zero outer count: straight to done on the next cycle, no beats.
    start_run(7, 0, 4);
    wait_done(1, "zero");
    chk(out_valid == 1'b0, "zero_no_valid", int'(out_valid), 0);
    check_idle("zero_idle_after");

    // Reset after the third transfer.
    push_run(10, 2, 3, 3);
    target = xfer_count + 3;
    start_run(10, 2, 3);
    for (int k = 0; k < 30 && xfer_count < target; k++) begin
      @(posedge ap_clk); #1;
    end
    chk(xfer_count >= target, "rst_three_xfers", xfer_count, target);
    ap_rst = 1'b1;
    dseen = done_seen;
    @(posedge ap_clk); #1;
    ap_rst = 1'b0;
    @(negedge ap_clk);
    chk(!out_valid && ap_idle && !ap_done, "rst_midrun_state", int'({out_valid, ap_idle, ap_done}), 2);
    repeat (3) @(negedge ap_clk);
    chk(done_seen == dseen, "rst_no_done", done_seen, dseen);
    chk(sb.size() == 0, "rst_drained", sb.size(), 0);

    // Back-to-back runs with ap_start held; config disturbed during the first run.
    push_run(50, 1, 2, -1);
    push_run(50, 1, 2, -1);
    @(posedge ap_clk); #1;
    a_base_in = 11'd50; a_count_in = 12'd1; b_count_in = 6'd2;
    ap_start = 1'b1;
    @(posedge ap_clk); #1;
    a_base_in = 11'd300; a_count_in = 12'd3; b_count_in = 6'd5;
    @(posedge ap_clk); #1;
    a_base_in = 11'd50; a_count_in = 12'd1; b_count_in = 6'd2;
    wait_done(10, "b2b_first");
    d1 = done_cyc;
    @(negedge ap_clk);
    chk(ap_idle == 1'b1, "b2b_single_idle", int'(ap_idle), 1);
    @(negedge ap_clk);
    chk(!ap_idle && out_valid, "b2b_restart", int'({ap_idle, out_valid}), 1);
    @(posedge ap_clk); #1;
    ap_start = 1'b0;
    wait_done(10, "b2b_second");
    chk(done_cyc - d1 == 4, "b2b_spacing", done_cyc - d1, 4);
    chk(sb.size() == 0, "b2b_drained", sb.size(), 0);
    check_idle("b2b_idle_after");

    repeat (2) @(posedge ap_clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
